// File: rtl/fifo_drain_if.sv
// Handshake bundle between an upstream FIFO head, the fifo_drain skid stage and its downstream consumer.
// The master modport is the fifo_drain side; the slave modport is the environment around it.
interface fifo_drain_if #(parameter int width = 1) ();
    // Upstream: EMPTY_N flags a valid head, one pop per cycle with DEQ high.
    // Downstream: a word moves on every posedge where VALID && READY.
    // DEQ never depends on READY.
    logic             EMPTY_N;
    logic [width-1:0] D_IN;
    logic             DEQ;
    logic [width-1:0] D_OUT;
    logic             VALID;
    logic             READY;
    logic             CLR;

    modport master (
        input  EMPTY_N, D_IN, READY, CLR,
        output DEQ, D_OUT, VALID
    );

    modport slave (
        output EMPTY_N, D_IN, READY, CLR,
        input  DEQ, D_OUT, VALID
    );
endinterface

// File: rtl/fifo_drain.sv
// Two-entry skid buffer draining an upstream FIFO into a valid/ready consumer.
// Optional FIFO_DRAIN_COUNT_EN adds COUNT, a wrapping tally of downstream transfers.
module fifo_drain #(
    parameter int width = 1
) (
    input  logic               CLK,
    input  logic               RST,
    fifo_drain_if.master       bus,
    output logic [1:0]         dbg_state
`ifdef FIFO_DRAIN_COUNT_EN
    ,
    output logic [15:0]        COUNT
`endif
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [width-1:0] head_q, head_d;
    logic [width-1:0] skid_q, skid_d;
    logic             push;
    logic             pop;

    // DEQ looks only at registered occupancy, so READY never reaches it.
    assign bus.DEQ   = RST && bus.EMPTY_N && (state_q != S_TWO) && !bus.CLR;
    assign bus.VALID = (state_q != S_EMPTY);
    assign bus.D_OUT = head_q;
    assign dbg_state = state_q;

    assign push = bus.DEQ;
    assign pop  = bus.VALID && bus.READY;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (bus.CLR) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        state_d = S_ONE;
                        head_d  = bus.D_IN;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        head_d = bus.D_IN;
                    end else if (push) begin
                        state_d = S_TWO;
                        skid_d  = bus.D_IN;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    // Only a pop can happen here; the skid word slides into the head.
                    if (pop) begin
                        state_d = S_ONE;
                        head_d  = skid_q;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

`ifdef FIFO_DRAIN_COUNT_EN
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (bus.CLR) begin
            count_d = 16'd0;
        end else if (pop) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign COUNT = count_q;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (RST) begin
            assert (!(bus.DEQ && !bus.EMPTY_N))
            else $warning("fifo_drain: DEQ high while EMPTY_N low");
        end
    end
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain at width 8: directed scenarios plus randomized traffic checked against a queue model.
module tb_fifo_drain;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [1:0]   dbg_state;
`ifdef FIFO_DRAIN_COUNT_EN
    logic [15:0]  count;
`endif

    fifo_drain_if #(.width(W)) bus ();

    fifo_drain #(.width(W)) dut (
        .CLK       (clk),
        .RST       (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
`ifdef FIFO_DRAIN_COUNT_EN
        ,
        .COUNT     (count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: buffered words in arrival order, plus transfer tally.
    logic [W-1:0] exp_q[$];
    logic [15:0]  exp_cnt;
    int           tests;
    int           fails;

    function automatic bit exp_deq();
        return rst_n && bus.EMPTY_N && (exp_q.size() < 2) && !bus.CLR;
    endfunction

    task automatic tick();
        bit push;
        bit pop;
        push = exp_deq();
        pop  = (exp_q.size() > 0) && bus.READY;
        if (bus.CLR) begin
            exp_q.delete();
            exp_cnt = 16'd0;
        end else begin
            if (pop) begin
                void'(exp_q.pop_front());
                exp_cnt = exp_cnt + 16'd1;
            end
            if (push) exp_q.push_back(bus.D_IN);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.EMPTY_N = 1'b0;
        bus.READY   = 1'b1;
        bus.CLR     = 1'b0;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.EMPTY_N = 1'b1;
        bus.D_IN    = 8'h5A;
        bus.READY   = 1'b1;
        bus.CLR     = 1'b0;
        exp_q.delete();
        exp_cnt = 16'd0;
        #12;
        tests++; if (bus.VALID !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus.VALID); end
        tests++; if (bus.DEQ !== 1'b0) begin fails++; $display("FAIL reset_deq: got %b expected 0", bus.DEQ); end
        tests++; if (bus.D_OUT !== 8'h00) begin fails++; $display("FAIL reset_dout: got %h expected 00", bus.D_OUT); end
        tests++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        bus.EMPTY_N = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_streaming();
        bus.EMPTY_N = 1'b1;
        bus.READY   = 1'b1;
        bus.CLR     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.D_IN = 8'(i + 1);
            if (i == 3) bus.EMPTY_N = 1'b0;
            #1;
            if (i < 3) begin
                tests++; if (bus.DEQ !== 1'b1) begin fails++; $display("FAIL stream_deq[%0d]: got %b expected 1", i, bus.DEQ); end
            end
            if (i > 0) begin
                tests++; if (bus.VALID !== 1'b1) begin fails++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, bus.VALID); end
                tests++; if (bus.D_OUT !== 8'(i)) begin fails++; $display("FAIL stream_dout[%0d]: got %h expected %h", i, bus.D_OUT, 8'(i)); end
            end
            tick();
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] heads [3];
        int k;
        heads[0] = 8'hA1; heads[1] = 8'hA2; heads[2] = 8'hA3;
        k = 0;
        bus.READY   = 1'b0;
        bus.CLR     = 1'b0;
        bus.EMPTY_N = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus.D_IN = heads[k];
            #1;
            tests++; if (bus.DEQ !== (c < 2)) begin fails++; $display("FAIL bp_deq[%0d]: got %b expected %b", c, bus.DEQ, (c < 2)); end
            if (c >= 2) begin
                tests++; if (bus.VALID !== 1'b1 || bus.D_OUT !== 8'hA1) begin fails++; $display("FAIL bp_stable[%0d]: got %b/%h expected 1/a1", c, bus.VALID, bus.D_OUT); end
            end
            if (bus.DEQ) k++;
            tick();
        end
        tests++; if (dbg_state !== 2'd2) begin fails++; $display("FAIL bp_full_state: got %0d expected 2", dbg_state); end
        bus.READY = 1'b1;
        for (int j = 0; j < 3; j++) begin
            if (k < 3) begin
                bus.EMPTY_N = 1'b1;
                bus.D_IN    = heads[k];
            end else begin
                bus.EMPTY_N = 1'b0;
            end
            #1;
            tests++; if (bus.VALID !== 1'b1 || bus.D_OUT !== heads[j]) begin fails++; $display("FAIL bp_order[%0d]: got %b/%h expected 1/%h", j, bus.VALID, bus.D_OUT, heads[j]); end
            if (bus.DEQ) k++;
            tick();
        end
        drain();
    endtask

    task automatic test_push_pop_one();
        bus.CLR     = 1'b0;
        bus.READY   = 1'b0;
        bus.EMPTY_N = 1'b1;
        bus.D_IN    = 8'h10;
        #1;
        tick();
        bus.READY = 1'b1;
        bus.D_IN  = 8'h11;
        #1;
        tests++; if (bus.DEQ !== 1'b1 || bus.D_OUT !== 8'h10) begin fails++; $display("FAIL pp_before: got deq=%b dout=%h expected 1/10", bus.DEQ, bus.D_OUT); end
        tick();
        bus.EMPTY_N = 1'b0;
        bus.READY   = 1'b0;
        #1;
        tests++; if (dbg_state !== 2'd1) begin fails++; $display("FAIL pp_state: got %0d expected 1", dbg_state); end
        tests++; if (bus.VALID !== 1'b1 || bus.D_OUT !== 8'h11) begin fails++; $display("FAIL pp_dout: got %b/%h expected 1/11", bus.VALID, bus.D_OUT); end
        drain();
    endtask

    task automatic test_clr();
        int deqs;
        deqs = 0;
        bus.CLR     = 1'b0;
        bus.READY   = 1'b0;
        bus.EMPTY_N = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.D_IN = 8'hC0 + 8'(c);
            #1;
            if (bus.DEQ) deqs++;
            tick();
        end
        bus.CLR   = 1'b1;
        bus.READY = 1'b1;
        #1;
        tests++; if (bus.DEQ !== 1'b0) begin fails++; $display("FAIL clr_deq: got %b expected 0", bus.DEQ); end
        tick();
        bus.CLR     = 1'b0;
        bus.EMPTY_N = 1'b0;
        #1;
        tests++; if (bus.VALID !== 1'b0 || dbg_state !== 2'd0) begin fails++; $display("FAIL clr_empty: got valid=%b state=%0d expected 0/0", bus.VALID, dbg_state); end
        tests++; if (deqs !== 2) begin fails++; $display("FAIL clr_upstream_pops: got %0d expected 2", deqs); end
`ifdef FIFO_DRAIN_COUNT_EN
        tests++; if (count !== 16'd0) begin fails++; $display("FAIL clr_count: got %h expected 0000", count); end
`endif
        drain();
    endtask

    task automatic test_async_reset();
        bus.CLR     = 1'b0;
        bus.READY   = 1'b0;
        bus.EMPTY_N = 1'b1;
        bus.D_IN    = 8'h77;
        #1;
        tick();
        tick();
        #2 rst_n = 1'b0;
        exp_q.delete();
        exp_cnt = 16'd0;
        #1;
        tests++; if (bus.VALID !== 1'b0 || bus.DEQ !== 1'b0 || bus.D_OUT !== 8'h00) begin fails++; $display("FAIL arst_outputs: got %b/%b/%h expected 0/0/00", bus.VALID, bus.DEQ, bus.D_OUT); end
        #2 rst_n = 1'b1;
        bus.READY = 1'b1;
        bus.D_IN  = 8'h55;
        #1;
        tests++; if (bus.DEQ !== 1'b1 || bus.VALID !== 1'b0) begin fails++; $display("FAIL arst_resume_deq: got deq=%b valid=%b expected 1/0", bus.DEQ, bus.VALID); end
        tick();
        bus.EMPTY_N = 1'b0;
        #1;
        tests++; if (bus.VALID !== 1'b1 || bus.D_OUT !== 8'h55) begin fails++; $display("FAIL arst_resume_dout: got %b/%h expected 1/55", bus.VALID, bus.D_OUT); end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            bus.EMPTY_N = ($urandom_range(0, 3) != 0);
            bus.D_IN    = 8'($urandom);
            bus.READY   = ($urandom_range(0, 2) != 0);
            bus.CLR     = ($urandom_range(0, 31) == 0);
            #1;
            tests++; if (bus.DEQ !== exp_deq()) begin fails++; $display("FAIL rand_deq[%0d]: got %b expected %b", c, bus.DEQ, exp_deq()); end
            tests++; if (bus.VALID !== (exp_q.size() > 0)) begin fails++; $display("FAIL rand_valid[%0d]: got %b expected %b", c, bus.VALID, (exp_q.size() > 0)); end
            if (exp_q.size() > 0) begin
                tests++; if (bus.D_OUT !== exp_q[0]) begin fails++; $display("FAIL rand_dout[%0d]: got %h expected %h", c, bus.D_OUT, exp_q[0]); end
            end
`ifdef FIFO_DRAIN_COUNT_EN
            tests++; if (count !== exp_cnt) begin fails++; $display("FAIL rand_count[%0d]: got %h expected %h", c, count, exp_cnt); end
`endif
            tick();
        end
        drain();
    endtask

`ifdef FIFO_DRAIN_COUNT_EN
    task automatic test_count_wrap();
        bus.CLR     = 1'b1;
        bus.EMPTY_N = 1'b0;
        bus.READY   = 1'b1;
        #1;
        tick();
        bus.CLR     = 1'b0;
        bus.EMPTY_N = 1'b1;
        for (int c = 0; c < 65538; c++) begin
            bus.D_IN = 8'(c);
            tick();
        end
        tests++; if (count !== 16'h0001) begin fails++; $display("FAIL count_wrap: got %h expected 0001", count); end
        tests++; if (count !== exp_cnt) begin fails++; $display("FAIL count_model: got %h expected %h", count, exp_cnt); end
        drain();
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_push_pop_one();
        test_clr();
        test_async_reset();
        test_random();
`ifdef FIFO_DRAIN_COUNT_EN
        test_count_wrap();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
